// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF stage with PC, imem request, 2-entry skid FIFO and IF/ID register
// Optional feature macro: FETCH_PERF_EN (adds o_perf_fetched / o_perf_stalls counters)
module fetch_unit #(
  parameter logic [31:0] RESET_PC         = 32'h0000_0000,
  parameter int unsigned RST_STALL_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall_pc,
  input  logic        i_stall_if_id,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_inst,
  output logic        o_if_valid,
  output logic        o_rst_stall
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] o_perf_fetched,
  output logic [31:0] o_perf_stalls
`endif
);

  typedef enum logic {S_HOLD, S_RUN} state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;
  // 0 and 1 both leave HOLD on the first edge after reset release
  localparam logic [3:0] CNT_LAST = (RST_STALL_CYCLES == 0) ? 4'd0 : 4'(RST_STALL_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rst_stall_q, rst_stall_d;
  logic [31:0] pc_q, pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] tag_q, tag_d;
  logic [31:0] fifo_pc_q [2];
  logic [31:0] fifo_pc_d [2];
  logic [31:0] fifo_inst_q [2];
  logic [31:0] fifo_inst_d [2];
  logic [1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        if_valid_q, if_valid_d;

  logic        run;
  logic        redirect;
  logic        credit;
  logic        req;
  logic        accept;
  logic        resp;
  logic        push;
  logic [1:0]  fill;

  // Next-state for the FSM, PC, request tracking, skid FIFO and IF/ID register
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rst_stall_d = rst_stall_q;
    pc_d        = pc_q;
    inflight_d  = inflight_q;
    tag_d       = tag_q;
    fifo_pc_d   = fifo_pc_q;
    fifo_inst_d = fifo_inst_q;
    fifo_cnt_d  = fifo_cnt_q;
    if_pc_d     = if_pc_q;
    if_inst_d   = if_inst_q;
    if_valid_d  = if_valid_q;
    push        = 1'b0;
    fill        = fifo_cnt_q;

    run      = (state_q == S_RUN);
    redirect = run && i_redirect;
    // Buffered plus outstanding words never exceed FIFO depth
    credit   = ({1'b0, fifo_cnt_q} + {2'b00, inflight_q}) < 3'd2;
    req      = run && !i_stall_pc && !i_redirect && credit;
    accept   = req && i_imem_ready;
    resp     = i_imem_rvalid && inflight_q;

    if (!run) begin
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == CNT_LAST) begin
        state_d     = S_RUN;
        rst_stall_d = 1'b0;
      end
    end

    if (redirect) begin
      pc_d       = i_redirect_pc & ~32'h3;
      inflight_d = 1'b0;
      fifo_cnt_d = 2'd0;
      if_valid_d = 1'b0;
      if_inst_d  = NOP;
    end else begin
      if (accept) begin
        pc_d  = pc_q + 32'd4;
        tag_d = pc_q;
      end
      inflight_d = accept;

      if (!i_stall_if_id) begin
        if (fifo_cnt_q != 2'd0) begin
          if_pc_d        = fifo_pc_q[0];
          if_inst_d      = fifo_inst_q[0];
          if_valid_d     = 1'b1;
          fifo_pc_d[0]   = fifo_pc_q[1];
          fifo_inst_d[0] = fifo_inst_q[1];
          fill           = fifo_cnt_q - 2'd1;
          push           = resp;
        end else if (resp) begin
          if_pc_d    = tag_q;
          if_inst_d  = i_imem_rdata;
          if_valid_d = 1'b1;
        end else begin
          if_valid_d = 1'b0;
          if_inst_d  = NOP;
        end
      end else begin
        push = resp;
      end

      if (push) begin
        fifo_pc_d[fill[0]]   = tag_q;
        fifo_inst_d[fill[0]] = i_imem_rdata;
        fifo_cnt_d           = fill + 2'd1;
      end else begin
        fifo_cnt_d = fill;
      end
    end
  end

  // State registers; reset restarts the post-reset hold sequence
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q        <= S_HOLD;
      cnt_q          <= 4'd0;
      rst_stall_q    <= 1'b1;
      pc_q           <= RESET_PC;
      inflight_q     <= 1'b0;
      tag_q          <= 32'd0;
      fifo_pc_q[0]   <= 32'd0;
      fifo_pc_q[1]   <= 32'd0;
      fifo_inst_q[0] <= NOP;
      fifo_inst_q[1] <= NOP;
      fifo_cnt_q     <= 2'd0;
      if_pc_q        <= 32'd0;
      if_inst_q      <= NOP;
      if_valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rst_stall_q <= rst_stall_d;
      pc_q        <= pc_d;
      inflight_q  <= inflight_d;
      tag_q       <= tag_d;
      fifo_pc_q   <= fifo_pc_d;
      fifo_inst_q <= fifo_inst_d;
      fifo_cnt_q  <= fifo_cnt_d;
      if_pc_q     <= if_pc_d;
      if_inst_q   <= if_inst_d;
      if_valid_q  <= if_valid_d;
    end
  end

  assign o_imem_req  = req;
  assign o_imem_addr = pc_q;
  assign o_if_pc     = if_pc_q;
  assign o_if_inst   = if_inst_q;
  assign o_if_valid  = if_valid_q;
  assign o_rst_stall = rst_stall_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;

  // Count valid IF/ID loads and RUN cycles spent with IF/ID held
  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_stalls_d  = perf_stalls_q;
    if (if_valid_d && !i_stall_if_id) perf_fetched_d = perf_fetched_q + 32'd1;
    if (run && i_stall_if_id) perf_stalls_d = perf_stalls_q + 32'd1;
  end

  // Performance counter registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      perf_fetched_q <= 32'd0;
      perf_stalls_q  <= 32'd0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stalls_q  <= perf_stalls_d;
    end
  end

  assign o_perf_fetched = perf_fetched_q;
  assign o_perf_stalls  = perf_stalls_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit with in-order delivery scoreboard
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        i_clk;
  logic        i_rst;
  logic        i_stall_pc;
  logic        i_stall_if_id;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ready;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata  = 32'd0;
  logic [31:0] o_if_pc;
  logic [31:0] o_if_inst;
  logic        o_if_valid;
  logic        o_rst_stall;

  int   checks    = 0;
  int   errors    = 0;
  int   delivered = 0;
  logic spur      = 1'b0;
  logic loaded    = 1'b0;
  ent_t sb[$];

  fetch_unit #(
    .RESET_PC         (32'h0000_0100),
    .RST_STALL_CYCLES (2)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_stall_pc    (i_stall_pc),
    .i_stall_if_id (i_stall_if_id),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_ready  (i_imem_ready),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .o_if_pc       (o_if_pc),
    .o_if_inst     (o_if_inst),
    .o_if_valid    (o_if_valid),
    .o_rst_stall   (o_rst_stall)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0F0F_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge i_clk);
  endtask

  // Memory model: data returns exactly one cycle after acceptance; spur injects stray rvalid
  initial begin
    logic        acc;
    logic [31:0] a;
    forever begin
      @(posedge i_clk);
      acc = o_imem_req && i_imem_ready && !i_rst;
      a   = o_imem_addr;
      #1;
      i_imem_rvalid = acc || spur;
      i_imem_rdata  = acc ? mem(a) : 32'hBAD0_BAD0;
    end
  end

  // Scoreboard: push accepted fetches, pop and compare on every valid IF/ID load
  initial begin
    ent_t e;
    forever begin
      @(posedge i_clk);
      loaded = !i_rst && !i_stall_if_id;
      if (i_rst) begin
        sb.delete();
      end else begin
        if (i_redirect && !o_rst_stall) sb.delete();
        if (o_imem_req && i_imem_ready) sb.push_back({o_imem_addr, mem(o_imem_addr)});
      end
      @(negedge i_clk);
      if (loaded && o_if_valid) begin
        chk("sb_depth", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("sb_pc", o_if_pc, e.pc);
          chk("sb_inst", o_if_inst, e.inst);
          delivered++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst         = 1'b1;
    i_stall_pc    = 1'b0;
    i_stall_if_id = 1'b0;
    i_redirect    = 1'b0;
    i_redirect_pc = 32'd0;
    i_imem_ready  = 1'b1;
    repeat (2) cyc();
    chk("rst_valid", o_if_valid, 0);
    chk("rst_pc", o_if_pc, 0);
    chk("rst_inst", o_if_inst, NOP);
    chk("rst_req", o_imem_req, 0);
    chk("rst_stall", o_rst_stall, 1);
    i_rst = 1'b0;

    // post-reset hold then first fetch
    cyc(); chk("hold1_stall", o_rst_stall, 1); chk("hold1_req", o_imem_req, 0);
    cyc(); chk("run_stall", o_rst_stall, 0); chk("run_req", o_imem_req, 1);
    chk("addr0", o_imem_addr, 32'h100);
    cyc(); chk("addr1", o_imem_addr, 32'h104); chk("lat_valid", o_if_valid, 0);
    cyc(); chk("first_valid", o_if_valid, 1); chk("first_pc", o_if_pc, 32'h100);
    chk("first_inst", o_if_inst, mem(32'h100)); chk("addr2", o_imem_addr, 32'h108);
    cyc(); chk("b2b_pc", o_if_pc, 32'h104); chk("addr3", o_imem_addr, 32'h10C);

    // both stalls: outputs frozen, no requests
    i_stall_pc = 1'b1; i_stall_if_id = 1'b1;
    #1 chk("stall_req_now", o_imem_req, 0);
    repeat (4) begin
      cyc();
      chk("frz_req", o_imem_req, 0);
      chk("frz_pc", o_if_pc, 32'h104);
      chk("frz_valid", o_if_valid, 1);
    end
    i_stall_pc = 1'b0; i_stall_if_id = 1'b0;
    cyc(); chk("rel_pc", o_if_pc, 32'h108); chk("rel_addr", o_imem_addr, 32'h110);
    cyc(); chk("rel_pc2", o_if_pc, 32'h10C);

    // IF/ID stall only: fetch continues until the FIFO is full
    i_stall_if_id = 1'b1;
    cyc(); chk("sid_req", o_imem_req, 0); chk("sid_pc", o_if_pc, 32'h10C);
    cyc(); chk("sid_req2", o_imem_req, 0);
    i_stall_if_id = 1'b0;
    #1 chk("credit_req", o_imem_req, 0);
    cyc(); chk("drain_pc", o_if_pc, 32'h110); chk("drain_req", o_imem_req, 1);
    chk("drain_addr", o_imem_addr, 32'h118);
    cyc(); chk("drain_pc2", o_if_pc, 32'h114);

    // redirect with a response in flight
    i_redirect = 1'b1; i_redirect_pc = 32'h203;
    #1 chk("redir_req", o_imem_req, 0);
    cyc(); chk("redir_valid", o_if_valid, 0); chk("redir_inst", o_if_inst, NOP);
    i_redirect = 1'b0;
    #1 chk("tgt_req", o_imem_req, 1); chk("tgt_addr", o_imem_addr, 32'h200);
    cyc(); chk("tgt_addr1", o_imem_addr, 32'h204);
    cyc(); chk("tgt_valid", o_if_valid, 1); chk("tgt_pc", o_if_pc, 32'h200);

    // memory back-pressure
    i_imem_ready = 1'b0;
    repeat (3) begin
      cyc();
      chk("rdy_req", o_imem_req, 1);
      chk("rdy_addr", o_imem_addr, 32'h208);
    end
    chk("rdy_drained", o_if_valid, 0);
    i_imem_ready = 1'b1;
    cyc();
    cyc(); chk("rdy_pc", o_if_pc, 32'h208); chk("rdy_valid", o_if_valid, 1);

    // asynchronous reset mid-fetch
    #2 i_rst = 1'b1;
    #1 chk("mid_valid", o_if_valid, 0); chk("mid_stall", o_rst_stall, 1);
    chk("mid_req", o_imem_req, 0); chk("mid_inst", o_if_inst, NOP);
    chk("mid_pc", o_if_pc, 0);
    cyc();
    i_rst = 1'b0; spur = 1'b1;
    cyc(); chk("re_hold", o_rst_stall, 1); chk("re_hold_valid", o_if_valid, 0);
    cyc(); chk("re_run", o_rst_stall, 0); chk("re_addr", o_imem_addr, 32'h100);
    spur = 1'b0;
    cyc(); chk("spur_ignored", o_if_valid, 0); chk("re_addr1", o_imem_addr, 32'h104);
    cyc(); chk("re_pc", o_if_pc, 32'h100); chk("re_valid", o_if_valid, 1);
    cyc();
    cyc();
    i_imem_ready = 1'b0;
    repeat (3) cyc();

    chk("delivered", delivered, 13);
    chk("sb_left", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
